// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register-file write port, with busy scoreboard
// Optional same-cycle bypass of the scoreboard: define REGFILE_WB_ARBITER_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  mark_valid,
  input  logic [ADDR_WIDTH-1:0] mark_addr,
  output logic                  mark_ready,
  input  logic [ADDR_WIDTH-1:0] chk_addr1,
  input  logic [ADDR_WIDTH-1:0] chk_addr2,
`ifdef REGFILE_WB_ARBITER_BYPASS_EN
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2,
`endif
  output logic                  busy1,
  output logic                  busy2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic             prio;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             winner;
  logic             handshake;
  logic             mark_take;
  logic             sb_busy1;
  logic             sb_busy2;

  // Contested cycles follow prio; otherwise whichever side is valid wins.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = prio;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  assign req0_ready = !rst && req0_valid && (winner == 1'b0);
  assign req1_ready = !rst && req1_valid && (winner == 1'b1);
  assign handshake  = req0_ready || req1_ready;

  assign rf_waddr = winner ? req1_addr : req0_addr;
  assign rf_wdata = winner ? req1_data : req0_data;
  assign rf_wen   = handshake && (rf_waddr != '0);

  assign mark_ready = !rst && (!busy[mark_addr] || (mark_addr == '0));
  assign mark_take  = mark_valid && mark_ready && (mark_addr != '0);

  // Clear is applied after set so a write always wins over a claim on the same register.
  always_comb begin
    busy_nxt = busy;
    if (mark_take) begin
      busy_nxt[mark_addr] = 1'b1;
    end
    if (handshake) begin
      busy_nxt[rf_waddr] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      if (handshake) begin
        prio <= ~winner;
      end
    end
  end

  assign sb_busy1 = !rst && busy[chk_addr1];
  assign sb_busy2 = !rst && busy[chk_addr2];

`ifdef REGFILE_WB_ARBITER_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1      = rf_wen && (rf_waddr == chk_addr1);
  assign hit2      = rf_wen && (rf_waddr == chk_addr2);
  assign busy1     = sb_busy1 && !hit1;
  assign busy2     = sb_busy2 && !hit2;
  assign fwd_data1 = hit1 ? rf_wdata : '0;
  assign fwd_data2 = hit2 ? rf_wdata : '0;
`else
  assign busy1 = sb_busy1;
  assign busy2 = sb_busy2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mark_valid, mark_ready;
  logic [4:0]  mark_addr, chk_addr1, chk_addr2;
  logic        busy1, busy2;
`ifdef REGFILE_WB_ARBITER_BYPASS_EN
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mark_valid(mark_valid), .mark_addr(mark_addr), .mark_ready(mark_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
`ifdef REGFILE_WB_ARBITER_BYPASS_EN
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .busy1(busy1), .busy2(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
    mark_valid = 1'b1; mark_addr = 5'd3;
    chk_addr1 = 5'd3; chk_addr2 = 5'd4;
    step(); step(); #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_mark_ready", mark_ready, 0);
    check("rst_busy1", busy1, 0);

    step();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; mark_valid = 1'b0;
    #1;
    check("idle_busy1", busy1, 0);
    check("idle_busy2", busy2, 0);
    check("idle_rf_wen", rf_wen, 0);
    check("idle_req0_ready", req0_ready, 0);
    check("idle_req1_ready", req1_ready, 0);

    step();
    mark_valid = 1'b1; mark_addr = 5'd5; #1;
    check("mark5_ready", mark_ready, 1);
    step();
    mark_valid = 1'b0; chk_addr1 = 5'd5; #1;
    check("mark5_busy1", busy1, 1);

    step();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF; #1;
    check("w5_req0_ready", req0_ready, 1);
    check("w5_rf_wen", rf_wen, 1);
    check("w5_rf_waddr", rf_waddr, 5);
    check("w5_rf_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    req0_valid = 1'b0; #1;
    check("w5_busy_cleared", busy1, 0);

    // req1-only write to x0 also returns prio to req0.
    step();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    mark_valid = 1'b1; mark_addr = 5'd0; #1;
    check("x0_req1_ready", req1_ready, 1);
    check("x0_rf_wen", rf_wen, 0);
    check("x0_mark_ready", mark_ready, 1);
    step();
    req1_valid = 1'b0; mark_valid = 1'b0; chk_addr1 = 5'd0; #1;
    check("x0_busy1", busy1, 0);

    step();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA0;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_req1_ready", req1_ready, (i % 2 == 0) ? 0 : 1);
      check("rr_rf_wdata", rf_wdata, (i % 2 == 0) ? 32'hA0 : 32'hB1);
      check("rr_rf_waddr", rf_waddr, (i % 2 == 0) ? 1 : 2);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    mark_valid = 1'b1; mark_addr = 5'd7; #1;
    check("mark7_ready", mark_ready, 1);
    step();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77; #1;
    check("mark7_clash_ready", mark_ready, 0);
    check("w7_req0_ready", req0_ready, 1);
    check("w7_rf_wen", rf_wen, 1);
    step();
    req0_valid = 1'b0; chk_addr1 = 5'd7; #1;
    check("w7_busy1", busy1, 0);
    check("remark7_ready", mark_ready, 1);
    step();
    mark_valid = 1'b0; #1;
    check("remark7_busy1", busy1, 1);

    step();
    mark_valid = 1'b1; mark_addr = 5'd3;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h70; #1;
    check("mark3_ready", mark_ready, 1);
    check("w7b_req1_ready", req1_ready, 1);
    step();
    mark_valid = 1'b0; req1_valid = 1'b0; chk_addr1 = 5'd3; chk_addr2 = 5'd7; #1;
    check("ab_busy3", busy1, 1);
    check("ab_busy7", busy2, 0);

    step();
    mark_valid = 1'b1; mark_addr = 5'd9; #1;
    check("mark9_ready", mark_ready, 1);
    step();
    mark_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h55; chk_addr2 = 5'd9; #1;
    check("w9_req1_ready", req1_ready, 1);
    check("w9_busy1_other", busy1, 1);
`ifdef REGFILE_WB_ARBITER_BYPASS_EN
    check("byp_busy2", busy2, 0);
    check("byp_fwd_data2", fwd_data2, 32'h55);
    check("byp_fwd_data1", fwd_data1, 0);
`else
    check("nobyp_busy2", busy2, 1);
`endif
    step();
    req1_valid = 1'b0; #1;
    check("w9_busy2_after", busy2, 0);

    // Leave prio pointing at req1 and a busy bit set, then reset mid-operation.
    step();
    mark_valid = 1'b1; mark_addr = 5'd4;
    req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66; #1;
    check("w6_req0_ready", req0_ready, 1);
    step();
    mark_valid = 1'b0; req0_valid = 1'b0;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; chk_addr1 = 5'd4; #1;
    check("mid_rst_req0_ready", req0_ready, 0);
    check("mid_rst_req1_ready", req1_ready, 0);
    check("mid_rst_busy1", busy1, 0);
    step();
    rst = 1'b0;
    req0_addr = 5'd10; req0_data = 32'hA; req1_addr = 5'd11; req1_data = 32'hB; #1;
    check("post_rst_busy4", busy1, 0);
    check("post_rst_req0_ready", req0_ready, 1);
    check("post_rst_req1_ready", req1_ready, 0);
    check("post_rst_rf_wdata", rf_wdata, 32'hA);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
